// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator with a pixel-clock enable, line/frame strobes and a frame counter.
// Define VGA_TIMING_ALIGN_EN to delay hs/vs/blank_n by one extra pixel tick.
module vga_timing_gen #(
    parameter int       CLK_DIV  = 2,
    parameter int       H_ACTIVE = 640,
    parameter int       H_FP     = 16,
    parameter int       H_SYNC   = 96,
    parameter int       H_BP     = 48,
    parameter int       V_ACTIVE = 480,
    parameter int       V_FP     = 10,
    parameter int       V_SYNC   = 2,
    parameter int       V_BP     = 33,
    parameter bit       HS_POL   = 1'b0,
    parameter bit       VS_POL   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       pix_tick_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       blank_n_o,
    output logic       active_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_count_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hCnt_q, hCnt_d;
    logic [9:0]       vCnt_q, vCnt_d;
    logic [7:0]       frameCnt_q, frameCnt_d;
    logic             pixTick;

    logic             visible;
    logic             hsLevel;
    logic             vsLevel;
    logic             lineFirst;
    logic             frameFirst;

    logic [9:0]       x_q, y_q;
    logic             active_q;
    logic             hs_q, vs_q, blank_q;
    logic             lineStart_q, frameStart_q;

    assign pixTick = en_i && (div_q == DIV_LAST);

    // Divider and raster counters; everything freezes while en_i is low.
    always_comb begin
        div_d      = div_q;
        hCnt_d     = hCnt_q;
        vCnt_d     = vCnt_q;
        frameCnt_d = frameCnt_q;
        if (en_i) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (pixTick) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                if (vCnt_q == V_LAST) begin
                    vCnt_d     = '0;
                    frameCnt_d = frameCnt_q + 1'b1;
                end else begin
                    vCnt_d = vCnt_q + 1'b1;
                end
            end else begin
                hCnt_d = hCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        visible    = (int'(hCnt_q) < H_ACTIVE) && (int'(vCnt_q) < V_ACTIVE);
        hsLevel    = ((int'(hCnt_q) >= HS_START) && (int'(hCnt_q) < HS_END)) ? HS_POL : ~HS_POL;
        vsLevel    = ((int'(vCnt_q) >= VS_START) && (int'(vCnt_q) < VS_END)) ? VS_POL : ~VS_POL;
        lineFirst  = (hCnt_q == '0);
        frameFirst = (hCnt_q == '0) && (vCnt_q == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q      <= '0;
            hCnt_q     <= '0;
            vCnt_q     <= '0;
            frameCnt_q <= '0;
        end else begin
            div_q      <= div_d;
            hCnt_q     <= hCnt_d;
            vCnt_q     <= vCnt_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    // Output stage captures the decode of the position that is about to advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q          <= '0;
            y_q          <= '0;
            active_q     <= 1'b0;
            hs_q         <= ~HS_POL;
            vs_q         <= ~VS_POL;
            blank_q      <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else if (pixTick) begin
            x_q          <= hCnt_q;
            y_q          <= vCnt_q;
            active_q     <= visible;
            hs_q         <= hsLevel;
            vs_q         <= vsLevel;
            blank_q      <= visible;
            lineStart_q  <= lineFirst;
            frameStart_q <= frameFirst;
        end
    end

`ifdef VGA_TIMING_ALIGN_EN
    logic hsAlign_q, vsAlign_q, blankAlign_q;

    // Extra stage lines sync/blank up with a colour stage that is one pixel behind x/y.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsAlign_q    <= ~HS_POL;
            vsAlign_q    <= ~VS_POL;
            blankAlign_q <= 1'b0;
        end else if (pixTick) begin
            hsAlign_q    <= hs_q;
            vsAlign_q    <= vs_q;
            blankAlign_q <= blank_q;
        end
    end

    assign hs_o      = hsAlign_q;
    assign vs_o      = vsAlign_q;
    assign blank_n_o = blankAlign_q;
`else
    assign hs_o      = hs_q;
    assign vs_o      = vs_q;
    assign blank_n_o = blank_q;
`endif

    assign pix_tick_o    = pixTick;
    assign active_o      = active_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = lineStart_q;
    assign frame_start_o = frameStart_q;
    assign frame_count_o = frameCnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance for whole-frame behaviour.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       en2 = 1'b0;

    logic       pix_tick, hs, vs, blank_n, active, line_start, frame_start;
    logic [9:0] x, y;
    logic [7:0] frame_count;

    logic       pix_tick2, hs2, vs2, blank_n2, active2, line_start2, frame_start2;
    logic [9:0] x2, y2;
    logic [7:0] frame_count2;

    int checkCount = 0;
    int passCount  = 0;

    always #10 clk = ~clk;

    vga_timing_gen dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .pix_tick_o(pix_tick), .hs_o(hs), .vs_o(vs), .blank_n_o(blank_n), .active_o(active),
        .x_o(x), .y_o(y), .line_start_o(line_start), .frame_start_o(frame_start),
        .frame_count_o(frame_count)
    );

    // Tiny raster: 16 pixels x 9 lines, one clock per pixel.
    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dutSmall (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2),
        .pix_tick_o(pix_tick2), .hs_o(hs2), .vs_o(vs2), .blank_n_o(blank_n2), .active_o(active2),
        .x_o(x2), .y_o(y2), .line_start_o(line_start2), .frame_start_o(frame_start2),
        .frame_count_o(frame_count2)
    );

`ifdef VGA_TIMING_ALIGN_EN
    localparam int EXP_HS_FIRST    = 657;
    localparam int EXP_BLANK_FALL  = 641;
    localparam bit EXP_FIRST_BLANK = 1'b0;
`else
    localparam int EXP_HS_FIRST    = 656;
    localparam int EXP_BLANK_FALL  = 640;
    localparam bit EXP_FIRST_BLANK = 1'b1;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Advance the default instance by exactly one pixel tick, sampling 1 ns after the edge.
    task automatic applyStimulus();
        bit got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (pix_tick) begin
                got = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            checkCount++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
    endtask

    initial begin
        int hsLow, firstHs, blankLow, blankFall, firstActLow, lsCount, lsX, highs;
        int vsLow2, fsCount2, fsFirst2, fsSecond2, xMax2;
        bit prevBlank;

        // Reset values with no clock edge involvement.
        #25;
        $display("[TB] reset state");
        checkOutput("rst_pix_tick", 32'(pix_tick), 0);
        checkOutput("rst_hs", 32'(hs), 1);
        checkOutput("rst_vs", 32'(vs), 1);
        checkOutput("rst_blank_n", 32'(blank_n), 0);
        checkOutput("rst_active", 32'(active), 0);
        checkOutput("rst_x", 32'(x), 0);
        checkOutput("rst_y", 32'(y), 0);
        checkOutput("rst_line_start", 32'(line_start), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst_frame_count", 32'(frame_count), 0);

        // Release reset with en=1: tick becomes high after the first clock and is consumed on the second.
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rel_tick_clk0", 32'(pix_tick), 0);
        @(posedge clk); #1;
        checkOutput("rel_tick_clk1", 32'(pix_tick), 1);
        checkOutput("rel_active_before_tick", 32'(active), 0);
        @(posedge clk); #1;
        checkOutput("first_tick_pix_tick_low", 32'(pix_tick), 0);
        checkOutput("first_tick_x", 32'(x), 0);
        checkOutput("first_tick_y", 32'(y), 0);
        checkOutput("first_tick_active", 32'(active), 1);
        checkOutput("first_tick_blank_n", 32'(blank_n), 32'(EXP_FIRST_BLANK));
        checkOutput("first_tick_frame_start", 32'(frame_start), 1);
        checkOutput("first_tick_line_start", 32'(line_start), 1);
        checkOutput("first_tick_hs", 32'(hs), 1);
        checkOutput("first_tick_vs", 32'(vs), 1);

        // Skip line 0, then observe every pixel of line 1.
        repeat (800) applyStimulus();
        checkOutput("line1_x", 32'(x), 0);
        checkOutput("line1_y", 32'(y), 1);
        checkOutput("line1_frame_start_low", 32'(frame_start), 0);
        $display("[TB] one full line");
        hsLow = 0; firstHs = -1; blankLow = 0; blankFall = -1; firstActLow = -1; lsCount = 0; lsX = -1;
        prevBlank = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (hs == 1'b0) begin
                hsLow++;
                if (firstHs < 0) firstHs = int'(x);
            end
            if (blank_n == 1'b0) blankLow++;
            if (!blank_n && prevBlank && blankFall < 0) blankFall = int'(x);
            prevBlank = blank_n;
            if (!active && firstActLow < 0) firstActLow = int'(x);
            if (line_start) begin
                lsCount++;
                lsX = int'(x);
            end
            applyStimulus();
        end
        checkOutput("line_hs_low_ticks", 32'(hsLow), 96);
        checkOutput("line_hs_first_x", 32'(firstHs), 32'(EXP_HS_FIRST));
        checkOutput("line_blank_low_ticks", 32'(blankLow), 160);
        checkOutput("line_blank_fall_x", 32'(blankFall), 32'(EXP_BLANK_FALL));
        checkOutput("line_active_fall_x", 32'(firstActLow), 640);
        checkOutput("line_start_count", 32'(lsCount), 1);
        checkOutput("line_start_x", 32'(lsX), 0);
        checkOutput("line2_y", 32'(y), 2);

        // Freeze at x=300 for 50 clocks, then resume without skipping.
        $display("[TB] enable freeze");
        repeat (300) applyStimulus();
        checkOutput("freeze_start_x", 32'(x), 300);
        en = 1'b0;
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (pix_tick) highs++;
        end
        checkOutput("freeze_pix_tick_highs", 32'(highs), 0);
        checkOutput("freeze_x_held", 32'(x), 300);
        en = 1'b1;
        applyStimulus();
        checkOutput("resume_x_301", 32'(x), 301);
        applyStimulus();
        checkOutput("resume_x_302", 32'(x), 302);

        // Asynchronous reset between edges in the middle of the sync pulse.
        repeat (398) applyStimulus();
        checkOutput("pre_reset_x", 32'(x), 700);
        checkOutput("pre_reset_hs", 32'(hs), 0);
        #4;
        rst_n = 1'b0;
        #1;
        $display("[TB] mid-line reset");
        checkOutput("async_rst_hs", 32'(hs), 1);
        checkOutput("async_rst_blank_n", 32'(blank_n), 0);
        checkOutput("async_rst_x", 32'(x), 0);
        checkOutput("async_rst_y", 32'(y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("post_rst_frame_start", 32'(frame_start), 1);
        checkOutput("post_rst_x", 32'(x), 0);
        checkOutput("post_rst_y", 32'(y), 0);
        applyStimulus();
        checkOutput("post_rst_x1", 32'(x), 1);
        checkOutput("post_rst_frame_start_low", 32'(frame_start), 0);

        // Two whole frames on the tiny raster: 16 x 9 = 144 ticks per frame.
        $display("[TB] two frames on small raster");
        en = 1'b0;
        checkOutput("small_idle_tick", 32'(pix_tick2), 0);
        @(negedge clk);
        en2 = 1'b1;
        vsLow2 = 0; fsCount2 = 0; fsFirst2 = -1; fsSecond2 = -1; xMax2 = 0;
        for (int i = 0; i < 288; i++) begin
            @(posedge clk); #1;
            if (vs2 == 1'b0) vsLow2++;
            if (int'(x2) > xMax2) xMax2 = int'(x2);
            if (frame_start2) begin
                fsCount2++;
                if (fsFirst2 < 0) fsFirst2 = i;
                else fsSecond2 = i;
            end
            if (i == 142) checkOutput("small_fc_before_wrap", 32'(frame_count2), 0);
            if (i == 143) checkOutput("small_fc_after_wrap", 32'(frame_count2), 1);
        end
        checkOutput("small_vs_low_ticks", 32'(vsLow2), 64);
        checkOutput("small_fs_count", 32'(fsCount2), 2);
        checkOutput("small_fs_first", 32'(fsFirst2), 0);
        checkOutput("small_fs_period", 32'(fsSecond2 - fsFirst2), 144);
        checkOutput("small_fc_final", 32'(frame_count2), 2);
        checkOutput("small_x_max", 32'(xMax2), 15);
        checkOutput("small_wrap_x", 32'(x2), 15);
        checkOutput("small_wrap_y", 32'(y2), 8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
